// File: rtl/mult_pkg.sv
// mult_pkg: widths shared with the 16x9 multiplier and the accumulator FSM state type.
package mult_pkg;
   localparam int MD_WD   = 16;
   localparam int MR_WD   = 9;
   localparam int PROD_WD = MD_WD + MR_WD;
   typedef enum logic [1:0] {IDLE, ACC, HOLD} acc_state_t;
endpackage

// File: rtl/prod_acc_if.sv
// prod_acc_if: product-beat input stream and frame-result output stream of prod_acc.
interface prod_acc_if #(
   parameter int PROD_WD = mult_pkg::PROD_WD,
   parameter int ACC_WD  = 32,
   parameter int CNT_WD  = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [PROD_WD-1:0] in_prod;
   logic               in_last;
   logic               out_valid;
   logic               out_ready;
   logic [ACC_WD-1:0]  out_acc;
   logic [CNT_WD-1:0]  out_cnt;
   logic               out_ovf;
   modport master (output in_valid, in_prod, in_last, out_ready,
                   input  in_ready, out_valid, out_acc, out_cnt, out_ovf);
   modport slave  (input  in_valid, in_prod, in_last, out_ready,
                   output in_ready, out_valid, out_acc, out_cnt, out_ovf);
endinterface

// File: rtl/prod_acc_sat_add.sv
// sat_add: zero-extending adder that clamps to all-ones and flags the carry-out.
module sat_add #(
   parameter int IN_WD  = 25,
   parameter int ACC_WD = 32
) (
   input  logic [ACC_WD-1:0] a,
   input  logic [IN_WD-1:0]  b,
   output logic [ACC_WD-1:0] sum,
   output logic              ovf
);
   logic [ACC_WD:0] s;
   assign s   = {1'b0, a} + (ACC_WD+1)'(b);
   assign ovf = s[ACC_WD];
   assign sum = ovf ? '1 : s[ACC_WD-1:0];
endmodule

// File: rtl/prod_acc.sv
// prod_acc: frame-delimited saturating accumulator for unsigned multiplier products,
// with valid/ready on both sides and handshakes decoded purely from the state register.
module prod_acc #(
   parameter int MD_WD   = mult_pkg::MD_WD,
   parameter int MR_WD   = mult_pkg::MR_WD,
   parameter int PROD_WD = MD_WD + MR_WD,
   parameter int ACC_WD  = 32,
   parameter int CNT_WD  = 8
) (
   input logic      clk,
   input logic      rst_n,
   prod_acc_if.slave bus
);
   import mult_pkg::*;
   if (ACC_WD < PROD_WD || CNT_WD < 1) begin : g_bad_params
      $error("prod_acc: need ACC_WD >= PROD_WD and CNT_WD >= 1");
   end
   acc_state_t        state, state_nx;
   logic [ACC_WD-1:0] acc, sum;
   logic [CNT_WD-1:0] cnt;
   logic              ovf, add_ovf, take;
   sat_add #(.IN_WD(PROD_WD), .ACC_WD(ACC_WD)) u_add (
      .a(acc), .b(bus.in_prod), .sum(sum), .ovf(add_ovf)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   always_comb begin
      take     = bus.in_valid && state != HOLD;
      state_nx = state == HOLD ? (bus.out_ready ? IDLE : HOLD) :
                 take          ? (bus.in_last ? HOLD : ACC)   : state;
   end
   // first beat of a frame reloads rather than adds, so HOLD->IDLE needs no clear cycle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (take) begin
         acc <= state == IDLE ? ACC_WD'(bus.in_prod) : sum;
         cnt <= state == IDLE ? CNT_WD'(1) : (&cnt ? cnt : cnt + 1'b1);
         ovf <= state == IDLE ? 1'b0 : ovf | add_ovf;
      end
   assign bus.in_ready  = state != HOLD;
   assign bus.out_valid = state == HOLD;
   assign bus.out_acc   = acc;
   assign bus.out_cnt   = cnt;
   assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_prod_acc.sv
// tb_prod_acc: directed table of beats plus hand sequences for saturation, backpressure and reset.
module tb_prod_acc;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   prod_acc_if #(.PROD_WD(25), .ACC_WD(32), .CNT_WD(8)) u_if ();
   prod_acc_if #(.PROD_WD(25), .ACC_WD(25), .CNT_WD(8)) s_if ();
   prod_acc #(.ACC_WD(32)) dut (.clk(clk), .rst_n(rst_n), .bus(u_if.slave));
   prod_acc #(.ACC_WD(25)) dut_s (.clk(clk), .rst_n(rst_n), .bus(s_if.slave));
   typedef struct {
      logic [24:0] prod;
      logic        last;
      int          gap;
      logic        ev;
      logic [31:0] acc;
      logic [7:0]  cnt;
      logic        ovf;
   } vec_t;
   vec_t vt[9];
   task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", n, got, exp);
      end
   endtask
   task automatic beat(input logic [24:0] p, input logic l);
      chk("ready_before_beat", 64'(u_if.in_ready), 64'd1);
      u_if.in_valid = 1'b1;
      u_if.in_prod  = p;
      u_if.in_last  = l;
      @(posedge clk);
      #1;
      u_if.in_valid = 1'b0;
   endtask
   task automatic result(input string n, input logic [31:0] a, input logic [7:0] c, input logic o);
      chk({n, "_valid"}, 64'(u_if.out_valid), 64'd1);
      chk({n, "_ready_low"}, 64'(u_if.in_ready), 64'd0);
      chk({n, "_acc"}, 64'(u_if.out_acc), 64'(a));
      chk({n, "_cnt"}, 64'(u_if.out_cnt), 64'(c));
      chk({n, "_ovf"}, 64'(u_if.out_ovf), 64'(o));
      u_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      u_if.out_ready = 1'b0;
      chk({n, "_idle_after"}, 64'(u_if.out_valid), 64'd0);
   endtask
   initial begin
      u_if.in_valid = 0; u_if.in_prod = 0; u_if.in_last = 0; u_if.out_ready = 0;
      s_if.in_valid = 0; s_if.in_prod = 0; s_if.in_last = 0; s_if.out_ready = 0;
      vt[0] = '{1234,     1, 0, 1, 1234,      1, 0};
      vt[1] = '{33488385, 0, 0, 0, 0,         0, 0};
      vt[2] = '{33488385, 0, 0, 0, 0,         0, 0};
      vt[3] = '{33488385, 0, 0, 0, 0,         0, 0};
      vt[4] = '{33488385, 1, 0, 1, 133953540, 4, 0};
      vt[5] = '{10,       0, 2, 0, 0,         0, 0};
      vt[6] = '{20,       0, 3, 0, 0,         0, 0};
      vt[7] = '{30,       1, 1, 1, 60,        3, 0};
      vt[8] = '{0,        1, 0, 1, 0,         1, 0};
      #2;
      chk("rst_valid", 64'(u_if.out_valid), 64'd0);
      chk("rst_ready", 64'(u_if.in_ready), 64'd1);
      chk("rst_acc", 64'(u_if.out_acc), 64'd0);
      chk("rst_cnt", 64'(u_if.out_cnt), 64'd0);
      chk("rst_ovf", 64'(u_if.out_ovf), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 9; i++) begin
         repeat (vt[i].gap) @(posedge clk);
         #0;
         beat(vt[i].prod, vt[i].last);
         if (vt[i].ev) result($sformatf("vec%0d", i), vt[i].acc, vt[i].cnt, vt[i].ovf);
         else chk($sformatf("vec%0d_novalid", i), 64'(u_if.out_valid), 64'd0);
      end
      // beat counter saturates while the sum keeps growing
      for (int i = 1; i <= 300; i++) beat(25'd1, i == 300);
      result("cnt_sat", 300, 255, 0);
      // backpressure: result held, input beats refused
      beat(25'd100, 1'b0);
      beat(25'd200, 1'b1);
      u_if.in_valid = 1'b1; u_if.in_prod = 25'd999; u_if.in_last = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", 64'(u_if.out_valid), 64'd1);
         chk("bp_ready", 64'(u_if.in_ready), 64'd0);
         chk("bp_acc", 64'(u_if.out_acc), 64'd300);
         chk("bp_cnt", 64'(u_if.out_cnt), 64'd2);
         @(posedge clk); #1;
      end
      u_if.in_valid = 1'b0;
      result("bp", 300, 2, 0);
      chk("bp_ready_idle", 64'(u_if.in_ready), 64'd1);
      beat(25'd5, 1'b1);
      result("bp_next", 5, 1, 0);
      // saturation on the narrow accumulator, then a clean frame
      s_if.in_valid = 1'b1; s_if.in_prod = 25'd33488385; s_if.in_last = 1'b0;
      @(posedge clk); #1;
      s_if.in_last = 1'b1;
      @(posedge clk); #1;
      s_if.in_valid = 1'b0;
      chk("sat_valid", 64'(s_if.out_valid), 64'd1);
      chk("sat_acc", 64'(s_if.out_acc), 64'd33554431);
      chk("sat_ovf", 64'(s_if.out_ovf), 64'd1);
      s_if.out_ready = 1'b1;
      @(posedge clk); #1;
      s_if.out_ready = 1'b0;
      s_if.in_valid = 1'b1; s_if.in_prod = 25'd5; s_if.in_last = 1'b1;
      @(posedge clk); #1;
      s_if.in_valid = 1'b0;
      chk("sat_next_valid", 64'(s_if.out_valid), 64'd1);
      chk("sat_next_acc", 64'(s_if.out_acc), 64'd5);
      chk("sat_next_ovf", 64'(s_if.out_ovf), 64'd0);
      s_if.out_ready = 1'b1;
      @(posedge clk); #1;
      s_if.out_ready = 1'b0;
      // reset mid-frame discards the partial frame
      beat(25'd50, 1'b0);
      beat(25'd60, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", 64'(u_if.out_valid), 64'd0);
      chk("mrst_acc", 64'(u_if.out_acc), 64'd0);
      chk("mrst_cnt", 64'(u_if.out_cnt), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mrst_no_result", 64'(u_if.out_valid), 64'd0);
      beat(25'd7, 1'b1);
      result("mrst", 7, 1, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
